// File: rtl/hwpe_stream_tcdm_fifo_load_credit_pkg.sv
// Shared types and helpers for the credit-based TCDM load decoupler.
// Optional feature macro used by the top: HWPE_STREAM_TCDM_LOAD_PERF_EN.
package hwpe_stream_package;

  // Widest address the request FIFO entry can carry.
  localparam int unsigned HWPE_STREAM_TCDM_ADDR_W = 32;

  // One buffered load request; a load only needs its address.
  typedef struct packed {
    logic [HWPE_STREAM_TCDM_ADDR_W-1:0] add;
  } tcdm_load_req_t;

  // Classification of an incoming TCDM response.
  typedef enum logic [1:0] {
    RESP_NONE,      // no response this cycle
    RESP_ACCEPT,    // belongs to an outstanding request, buffered
    RESP_DROP,      // stale response from before a clear, discarded
    RESP_SPURIOUS   // nothing outstanding at all, discarded and flagged
  } tcdm_resp_kind_e;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int unsigned HWPE_STREAM_TCDM_LOAD_CNT_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Circular pointer increment for FIFOs whose depth need not be a power of two.
  function automatic int unsigned hwpe_stream_ptr_next(input int unsigned ptr,
                                                       input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_fifo_load_credit_if.sv
// TCDM load port bundle. The streamer side connects through the slave
// modport, the interconnect side through the master modport.
interface hwpe_stream_tcdm_fifo_load_credit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_ready;

  // Initiator view: issues requests, receives grants and read data.
  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  // Target view: accepts load requests, returns read data under r_ready.
  modport slave (
    input  req, add, r_ready,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/hwpe_stream_tcdm_credit_counter.sv
// Response-credit bookkeeping: outstanding loads, stale responses still to
// be discarded after a clear, available credit and the sticky error flag.
module hwpe_stream_tcdm_credit_counter
  import hwpe_stream_package::*;
#(
  parameter int unsigned RESP_DEPTH = 8,
  parameter int unsigned CNT_W      = HWPE_STREAM_TCDM_LOAD_CNT_W(RESP_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            gnt_i,         // request handed to the interconnect
  input  logic            r_valid_i,     // response from the interconnect
  input  logic [CNT_W-1:0] resp_count_i, // entries held in the response FIFO
  output logic [CNT_W-1:0] credit_o,
  output tcdm_resp_kind_e resp_kind_o,
  output logic            err_o
);

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] outstanding;
  logic             err_q, err_d;
  tcdm_resp_kind_e  resp_kind;

  // Responses arrive in order, so stale ones (drop) are consumed before
  // any response belonging to a request issued after the clear.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // a variable unassigned would infer a latch.
  always_comb begin : classify_resp
    resp_kind = RESP_NONE;
    if (r_valid_i) begin
      if (drop_q != '0)          resp_kind = RESP_DROP;
      else if (inflight_q != '0) resp_kind = RESP_ACCEPT;
      else                       resp_kind = RESP_SPURIOUS;
    end
  end

  // Next-state for the counters; a clear turns everything still owed by the
  // interconnect into responses to be dropped, and wins over normal updates.
  // A clear while already dropping restarts the count from the live loads.
  always_comb begin : counter_next
    outstanding = inflight_q + CNT_W'(gnt_i) - CNT_W'(resp_kind == RESP_ACCEPT);
    inflight_d  = outstanding;
    drop_d      = drop_q - CNT_W'(resp_kind == RESP_DROP);
    err_d       = err_q | (resp_kind == RESP_SPURIOUS);
    if (clear_i) begin
      inflight_d = '0;
      drop_d     = outstanding;
      err_d      = 1'b0;
    end
  end

  // Counter state register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk_i) begin : counter_regs
    if (rst_i) begin
      inflight_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // A slot is free only if neither a buffered nor an in-flight response owns it.
  assign credit_o    = CNT_W'(RESP_DEPTH) - resp_count_i - inflight_q;
  assign resp_kind_o = resp_kind;
  assign err_o       = err_q;

endmodule

// File: rtl/hwpe_stream_tcdm_fifo_load_credit.sv
// TCDM load decoupler: request FIFO towards the interconnect, response FIFO
// towards the streamer, requests issued only against a reserved response slot.
// Optional macro HWPE_STREAM_TCDM_LOAD_PERF_EN adds saturating performance
// counters (grants, credit stalls, dropped responses).
// ADDR_WIDTH must not exceed HWPE_STREAM_TCDM_ADDR_W from the package.
module hwpe_stream_tcdm_fifo_load_credit
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned RESP_DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  hwpe_stream_tcdm_fifo_load_credit_if.slave  slave,
  hwpe_stream_tcdm_fifo_load_credit_if.master master,
  output logic err_o
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
  ,
  output logic [31:0] perf_req_o,
  output logic [31:0] perf_stall_o,
  output logic [15:0] perf_drop_o
`endif
);

  localparam int unsigned CNT_W      = HWPE_STREAM_TCDM_LOAD_CNT_W(RESP_DEPTH);
  localparam int unsigned REQ_CNT_W  = HWPE_STREAM_TCDM_LOAD_CNT_W(REQ_DEPTH);
  localparam int unsigned REQ_PTR_W  = $clog2(REQ_DEPTH);
  localparam int unsigned RESP_PTR_W = $clog2(RESP_DEPTH);

  // ---------------- request FIFO ----------------
  tcdm_load_req_t         req_mem_q [REQ_DEPTH];
  logic [REQ_PTR_W-1:0]   req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [REQ_CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic                   req_full, req_empty, req_push, req_pop;

  // ---------------- response FIFO ----------------
  logic [DATA_WIDTH-1:0]  resp_mem_q [RESP_DEPTH];
  logic [RESP_PTR_W-1:0]  resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic [CNT_W-1:0]       resp_cnt_q, resp_cnt_d;
  logic                   resp_empty, resp_push, resp_pop;

  logic [CNT_W-1:0]       credit;
  tcdm_resp_kind_e        resp_kind;

  assign req_full  = (req_cnt_q == REQ_CNT_W'(REQ_DEPTH));
  assign req_empty = (req_cnt_q == '0);
  assign req_push  = slave.req & ~req_full;
  assign req_pop   = master.req & master.gnt;

  assign resp_empty = (resp_cnt_q == '0);
  assign resp_push  = (resp_kind == RESP_ACCEPT);
  assign resp_pop   = slave.r_valid & slave.r_ready;

  // Pointer and occupancy update for the request FIFO; clear flushes it.
  always_comb begin : req_fifo_next
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    req_cnt_d = req_cnt_q + REQ_CNT_W'(req_push) - REQ_CNT_W'(req_pop);
    if (req_push) req_wr_d = REQ_PTR_W'(hwpe_stream_ptr_next(int'(req_wr_q), REQ_DEPTH));
    if (req_pop)  req_rd_d = REQ_PTR_W'(hwpe_stream_ptr_next(int'(req_rd_q), REQ_DEPTH));
    if (clear_i) begin
      req_wr_d  = '0;
      req_rd_d  = '0;
      req_cnt_d = '0;
    end
  end

  // Pointer and occupancy update for the response FIFO; clear flushes it.
  always_comb begin : resp_fifo_next
    resp_wr_d  = resp_wr_q;
    resp_rd_d  = resp_rd_q;
    resp_cnt_d = resp_cnt_q + CNT_W'(resp_push) - CNT_W'(resp_pop);
    if (resp_push) resp_wr_d = RESP_PTR_W'(hwpe_stream_ptr_next(int'(resp_wr_q), RESP_DEPTH));
    if (resp_pop)  resp_rd_d = RESP_PTR_W'(hwpe_stream_ptr_next(int'(resp_rd_q), RESP_DEPTH));
    if (clear_i) begin
      resp_wr_d  = '0;
      resp_rd_d  = '0;
      resp_cnt_d = '0;
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clk_i) begin : fifo_ctrl_regs
    if (rst_i) begin
      req_wr_q   <= '0;
      req_rd_q   <= '0;
      req_cnt_q  <= '0;
      resp_wr_q  <= '0;
      resp_rd_q  <= '0;
      resp_cnt_q <= '0;
    end else begin
      req_wr_q   <= req_wr_d;
      req_rd_q   <= req_rd_d;
      req_cnt_q  <= req_cnt_d;
      resp_wr_q  <= resp_wr_d;
      resp_rd_q  <= resp_rd_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  // FIFO storage writes.
  // NOTE: storage arrays are not reset; an entry is only read once the
  // pointers say it was written, and outputs are forced to 0 while empty.
  always_ff @(posedge clk_i) begin : fifo_storage
    if (req_push)  req_mem_q[req_wr_q]   <= '{add: HWPE_STREAM_TCDM_ADDR_W'(slave.add)};
    if (resp_push) resp_mem_q[resp_wr_q] <= master.r_data;
  end

  hwpe_stream_tcdm_credit_counter #(
    .RESP_DEPTH (RESP_DEPTH),
    .CNT_W      (CNT_W)
  ) i_credit (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .gnt_i        (req_pop),
    .r_valid_i    (master.r_valid),
    .resp_count_i (resp_cnt_q),
    .credit_o     (credit),
    .resp_kind_o  (resp_kind),
    .err_o        (err_o)
  );

  // Streamer side: registered FIFO state only, so nothing falls through.
  assign slave.gnt     = ~req_full;
  assign slave.r_valid = ~resp_empty;
  assign slave.r_data  = resp_empty ? '0 : resp_mem_q[resp_rd_q];

  // Interconnect side: the head stays put until granted, so the address is
  // stable across any grant back-pressure.
  assign master.req  = ~req_empty & (credit != '0);
  assign master.add  = req_empty ? '0 : ADDR_WIDTH'(req_mem_q[req_rd_q].add);
  assign master.wen  = 1'b1;
  assign master.be   = '1;
  assign master.data = '0;

`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_drop_q, perf_drop_d;

  // Saturating event counters; clear wins over a same-cycle event.
  always_comb begin : perf_next
    perf_req_d   = perf_req_q;
    perf_stall_d = perf_stall_q;
    perf_drop_d  = perf_drop_q;
    if (req_pop && perf_req_q != '1) perf_req_d = perf_req_q + 32'd1;
    if (!req_empty && credit == '0 && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    if (resp_kind == RESP_DROP && perf_drop_q != '1) perf_drop_d = perf_drop_q + 16'd1;
    if (clear_i) begin
      perf_req_d   = '0;
      perf_stall_d = '0;
      perf_drop_d  = '0;
    end
  end

  // Performance counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin : perf_regs
    if (rst_i) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_stall_q <= perf_stall_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_req_o   = perf_req_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_drop_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_load_credit.sv
// Directed bench for the credit-based TCDM load decoupler. A small TCDM
// responder returns {16'hDA7A, addr[15:0]} a programmable number of cycles
// after each grant; a streamer driver pushes a queue of addresses.
module tb_hwpe_stream_tcdm_fifo_load_credit;

  logic clk = 1'b0;
  logic rst_i, clear_i;
  logic err;
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
  logic [31:0] perf_req, perf_stall;
  logic [15:0] perf_drop;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  hwpe_stream_tcdm_fifo_load_credit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();
  hwpe_stream_tcdm_fifo_load_credit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();

  hwpe_stream_tcdm_fifo_load_credit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .REQ_DEPTH  (4),
    .RESP_DEPTH (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .slave   (s_if),
    .master  (m_if),
    .err_o   (err)
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
    ,
    .perf_req_o   (perf_req),
    .perf_stall_o (perf_stall),
    .perf_drop_o  (perf_drop)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus / responder state
  logic [31:0] push_q[$];
  logic [31:0] got_q[$];
  int          grants;
  int          lat;
  logic        last_rvalid;
  logic        pipe_v [8];
  logic [31:0] pipe_d [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle per iteration: record streamer pops, drive the responder,
  // drive the streamer, then advance to just after the next rising edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      logic grant;
      if (s_if.r_valid === 1'b1 && s_if.r_ready === 1'b1) got_q.push_back(s_if.r_data);
      m_if.r_valid = pipe_v[0];
      m_if.r_data  = pipe_v[0] ? pipe_d[0] : 32'h0;
      last_rvalid  = pipe_v[0];
      grant = (m_if.req === 1'b1) && (m_if.gnt === 1'b1);
      for (int i = 0; i < 7; i++) begin
        pipe_v[i] = pipe_v[i+1];
        pipe_d[i] = pipe_d[i+1];
      end
      pipe_v[7] = 1'b0;
      pipe_d[7] = 32'h0;
      if (grant) begin
        grants++;
        pipe_v[lat-1] = 1'b1;
        pipe_d[lat-1] = {16'hDA7A, m_if.add[15:0]};
      end
      s_if.req = (push_q.size() != 0);
      s_if.add = (push_q.size() != 0) ? push_q[0] : 32'h0;
      if (s_if.req && s_if.gnt === 1'b1) void'(push_q.pop_front());
      tick();
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_i = 1'b0;
    push_q.delete();
    got_q.delete();
    grants = 0;
    lat = 1;
    last_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 32'h0;
    end
    s_if.req = 1'b0; s_if.add = '0; s_if.r_ready = 1'b1;
    s_if.wen = 1'b1; s_if.be = '1; s_if.data = '0;
    m_if.gnt = 1'b1; m_if.r_valid = 1'b0; m_if.r_data = '0; m_if.r_ready = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Reset applied in the middle of traffic returns everything to idle.
  task automatic test_reset();
    do_reset();
    m_if.gnt = 1'b0;
    push_q = '{32'h0000_0700, 32'h0000_0704};
    run(3);
    do_reset();
    tests_run++;
    if ({s_if.gnt, s_if.r_valid, m_if.req, err} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {gnt,r_valid,req,err} got %b expected 1000",
               {s_if.gnt, s_if.r_valid, m_if.req, err});
    end
    tests_run++;
    if ({m_if.add, s_if.r_data, m_if.data} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_data: {add,r_data,data} got %h expected 0",
               {m_if.add, s_if.r_data, m_if.data});
    end
    tests_run++;
    if ({m_if.wen, m_if.be} !== 5'b11111) begin
      tests_failed++;
      $display("FAIL reset_wen_be: got %b expected 11111", {m_if.wen, m_if.be});
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_data [4];
    exp_data = '{32'hDA7A_0100, 32'hDA7A_0104, 32'hDA7A_0108, 32'hDA7A_010C};
    do_reset();
    push_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    s_if.req = 1'b1;
    s_if.add = 32'h100;
    #1;
    tests_run++;
    if (m_if.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_no_fallthrough: master_req got %b expected 0", m_if.req);
    end
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (s_if.r_valid !== last_rvalid) begin
        tests_failed++;
        $display("FAIL basic_latency[%0d]: slave_r_valid got %b expected %b", c, s_if.r_valid, last_rvalid);
      end
      run(1);
    end
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count: responses got %0d expected 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_q[i] !== exp_data[i]) begin
          tests_failed++;
          $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_credit_stall();
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
    logic [31:0] stall0;
`endif
    do_reset();
    s_if.r_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_q.push_back(32'h600 + 32'(4*i));
    run(30);
    tests_run++;
    if (grants != 8) begin
      tests_failed++;
      $display("FAIL stall_grants: got %0d expected 8", grants);
    end
    tests_run++;
    if ({m_if.req, s_if.gnt, s_if.r_valid} !== 3'b001) begin
      tests_failed++;
      $display("FAIL stall_state: {req,gnt,r_valid} got %b expected 001", {m_if.req, s_if.gnt, s_if.r_valid});
    end
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
    tests_run++;
    if (perf_req !== 32'd8) begin
      tests_failed++;
      $display("FAIL stall_perf_req: got %0d expected 8", perf_req);
    end
    stall0 = perf_stall;
    run(1);
    tests_run++;
    if (perf_stall !== stall0 + 32'd1) begin
      tests_failed++;
      $display("FAIL stall_perf_stall: got %0d expected %0d", perf_stall, stall0 + 32'd1);
    end
`endif
    s_if.r_ready = 1'b1;
    run(1);
    s_if.r_ready = 1'b0;
    run(8);
    tests_run++;
    if (grants != 9) begin
      tests_failed++;
      $display("FAIL stall_one_more_grant: got %0d expected 9", grants);
    end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDA7A_0600) begin
      tests_failed++;
      $display("FAIL stall_first_pop: count %0d expected 1 with data DA7A0600", got_q.size());
    end
    s_if.r_ready = 1'b1;
    run(40);
    tests_run++;
    if (got_q.size() != 12 || got_q[got_q.size()-1] !== 32'hDA7A_062C) begin
      tests_failed++;
      $display("FAIL stall_drain: count %0d expected 12 ending DA7A062C", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_if.gnt = 1'b0;
    for (int i = 0; i < 6; i++) push_q.push_back(32'h300 + 32'(4*i));
    run(4);
    tests_run++;
    if (s_if.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: slave_gnt got %b expected 0", s_if.gnt);
    end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (m_if.req !== 1'b1 || m_if.add !== 32'h300) begin
        tests_failed++;
        $display("FAIL bp_stable[%0d]: req %b add %h expected req 1 add 300", c, m_if.req, m_if.add);
      end
      run(1);
    end
    m_if.gnt = 1'b1;
    run(20);
    tests_run++;
    if (got_q.size() != 6 || got_q[0] !== 32'hDA7A_0300 || got_q[got_q.size()-1] !== 32'hDA7A_0314) begin
      tests_failed++;
      $display("FAIL bp_drain: count %0d expected 6 from DA7A0300 to DA7A0314", got_q.size());
    end
  endtask

  task automatic test_clear();
    do_reset();
    lat = 4;
    push_q = '{32'h400, 32'h404, 32'h408};
    run(4);
    tests_run++;
    if (grants != 3 || m_if.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_setup: grants %0d req %b expected 3 and 0", grants, m_if.req);
    end
    clear_i = 1'b1;
    run(1);
    clear_i = 1'b0;
    push_q.push_back(32'h200);
    run(12);
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL clear_count: responses got %0d expected 1", got_q.size());
    end else begin
      tests_run++;
      if (got_q[0] !== 32'hDA7A_0200) begin
        tests_failed++;
        $display("FAIL clear_data: got %h expected DA7A0200", got_q[0]);
      end
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_no_err: err got %b expected 0", err);
    end
`ifdef HWPE_STREAM_TCDM_LOAD_PERF_EN
    tests_run++;
    if (perf_drop !== 16'd3) begin
      tests_failed++;
      $display("FAIL clear_perf_drop: got %0d expected 3", perf_drop);
    end
`endif
  endtask

  task automatic test_spurious();
    do_reset();
    m_if.r_valid = 1'b1;
    m_if.r_data  = 32'hDEAD_BEEF;
    tick();
    m_if.r_valid = 1'b0;
    tests_run++;
    if ({err, s_if.r_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL spurious_err: {err,r_valid} got %b expected 10", {err, s_if.r_valid});
    end
    tick();
    tests_run++;
    if ({err, s_if.r_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL spurious_sticky: {err,r_valid} got %b expected 10", {err, s_if.r_valid});
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_clear: err got %b expected 0", err);
    end
  endtask

  // Second grant lands in the same cycle as the first response.
  task automatic test_same_cycle();
    do_reset();
    s_if.r_ready = 1'b0;
    push_q = '{32'h500, 32'h504};
    run(6);
    tests_run++;
    if (grants != 2) begin
      tests_failed++;
      $display("FAIL same_setup: grants got %0d expected 2", grants);
    end
    for (int i = 2; i < 9; i++) push_q.push_back(32'h500 + 32'(4*i));
    run(20);
    tests_run++;
    if (grants != 8 || m_if.req !== 1'b0 || s_if.gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_credit: grants %0d req %b gnt %b expected 8 0 1", grants, m_if.req, s_if.gnt);
    end
    s_if.r_ready = 1'b1;
    run(30);
    tests_run++;
    if (got_q.size() != 9 || got_q[got_q.size()-1] !== 32'hDA7A_0520) begin
      tests_failed++;
      $display("FAIL same_drain: count %0d expected 9 ending DA7A0520", got_q.size());
    end
  endtask

  initial begin
    rst_i = 1'b1;
    clear_i = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_credit_stall();
    test_backpressure();
    test_clear();
    test_spurious();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
